alu_cmd_sequencer: RTL
======================

Name: alu_cmd_sequencer

Overview:
Initiator side of the combinational ALU interface (opcodes 000 add, 001 sub, 010 gt, 011 lt).
- Accepts operand/opcode commands over valid/ready into a small FIFO.
- Drives one command per cycle onto the ALU input bus and captures the ALU result in the same cycle.
- Returns the tagged result over a valid/ready response port.
- Sits between a command producer (test sequencer or decode stage) and the ALU instance.

Parameters:
WIDTH, 32, operand/result width; matches the ALU datapath.
DEPTH, 4, command FIFO entries; power of two, >= 2.
TAG_W, 4, width of the command tag returned with each result.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
cmd_valid  input  1  command present.
cmd_ready  output  1  FIFO can accept; equals !full.
cmd_opcode  input  3  ALU opcode.
cmd_a  input  WIDTH  operand A.
cmd_b  input  WIDTH  operand B.
cmd_tag  input  TAG_W  command ID, echoed on the response.
alu_issue  output  1  high in the cycle a command is presented to the ALU.
alu_a  output  WIDTH  operand A to ALU; 0 when alu_issue=0.
alu_b  output  WIDTH  operand B to ALU; 0 when alu_issue=0.
alu_opcode  output  3  opcode to ALU; 3'b000 when alu_issue=0.
alu_result  input  WIDTH  combinational ALU result for the current alu_a/alu_b/alu_opcode.
rsp_valid  output  1  response register holds a result.
rsp_ready  input  1  consumer accepts the response.
rsp_result  output  WIDTH  captured ALU result.
rsp_opcode  output  3  opcode of the response.
rsp_tag  output  TAG_W  tag of the response.
occupancy  output  $clog2(DEPTH)+1  FIFO entry count.

Behaviour:
- Reset (async assert, sync release): FIFO empty, occupancy=0, rsp_valid=0, rsp_result/rsp_opcode/rsp_tag=0, state=IDLE. Reset mid-operation discards every queued and pending command.
- Push: cmd_valid && cmd_ready at a clock edge writes {opcode,a,b,tag}.
  - cmd_ready depends only on full. No push when full, even if a pop happens the same cycle.
- Issue condition: fifo_nonempty && (!rsp_valid || rsp_ready).
  - alu_issue=1 in that cycle; alu_a/alu_b/alu_opcode are driven from the FIFO head registers.
  - At the edge: pop the head, load rsp_result<=alu_result, rsp_opcode, rsp_tag, and set rsp_valid<=1.
- If rsp_valid && rsp_ready and there is no issue, rsp_valid<=0 at the edge.
- Latency: command accepted at edge ending cycle 0 with FIFO and response empty -> alu_issue in cycle 1 -> rsp_valid in cycle 2.
- Throughput: one result per cycle while rsp_ready=1.
- Stall: while rsp_valid && !rsp_ready, all rsp_* outputs hold stable, alu_issue=0, and the FIFO may still fill.
- Push and pop in the same edge: occupancy unchanged; ordering is strictly FIFO.
- Pointers: log2(DEPTH) bits, wrap naturally; occupancy is a separate counter, 0..DEPTH.
- Opcodes 1xx are not filtered: they are issued and whatever alu_result the ALU returns is captured.
- State machine (observable via behaviour only):
  - IDLE: FIFO empty, !rsp_valid.
  - RUN: issuing, or a response pending with rsp_ready.
  - STALL: rsp_valid && !rsp_ready.
  - IDLE->RUN on push; RUN->STALL when rsp_ready=0 with rsp_valid; STALL->RUN on rsp_ready; RUN->IDLE when FIFO empty and response drained.

Optional Feature:
Macro ALU_CMD_SEQ_CHECK_EN.
- Defined: adds output chk_mismatch (1, sticky) and chk_err_count (16, saturating).
  - Each issue cycle compares alu_result with an internal model: 000 a+b mod 2^WIDTH; 001 a-b mod 2^WIDTH; 010 zero-extended (a>b) unsigned; 011 zero-extended (a<b) unsigned; 1xx 0.
  - On mismatch: chk_mismatch<=1 and chk_err_count increments, saturating at 16'hFFFF.
  - Both clear only on reset.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Single add: cmd {000, A=5, B=7, tag=3} accepted cycle 0, rsp_ready=1 -> alu_issue cycle 1 with alu_a=5, alu_b=7; rsp_valid cycle 2, rsp_result=12, rsp_tag=3.
- Sub wrap: {001, A=0, B=1} -> rsp_result=32'hFFFF_FFFF. Then {010, A=9, B=2} -> 1; {011, A=9, B=2} -> 0.
- Backpressure/full: rsp_ready=0, push 6 commands back-to-back (DEPTH=4):
  - 1 issues to rsp; 4 fill the FIFO, occupancy=4, cmd_ready=0; the 6th is not accepted.
  - rsp_* stable throughout.
  - Then rsp_ready=1 -> 5 responses in order, one per cycle, tags preserved.
- Concurrent push/pop at occupancy=2 with rsp_ready=1 -> occupancy stays 2. Run 20 commands to exercise pointer wrap; order intact.
- Reset mid-stream: occupancy=3, rsp_valid=1, drop rst_n asynchronously -> rsp_valid=0 and occupancy=0 immediately; no stale response after release.
- With ALU_CMD_SEQ_CHECK_EN: force alu_result=0 for add 1+1 -> chk_mismatch=1, chk_err_count=1; correct results leave both unchanged.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Bus bundle between the ALU command sequencer and its environment: command, ALU and response channels.
// The master modport is the sequencer; the slave modport is the producer/ALU/consumer side.
interface alu_cmd_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_opcode;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  logic             alu_issue;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_opcode;
  logic [WIDTH-1:0] alu_result;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [2:0]       rsp_opcode;
  logic [TAG_W-1:0] rsp_tag;

  logic [OCC_W-1:0] occupancy;

  modport master (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, alu_result, rsp_ready,
    output cmd_ready, alu_issue, alu_a, alu_b, alu_opcode,
           rsp_valid, rsp_result, rsp_opcode, rsp_tag, occupancy
  );

  modport slave (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag, alu_result, rsp_ready,
    input  cmd_ready, alu_issue, alu_a, alu_b, alu_opcode,
           rsp_valid, rsp_result, rsp_opcode, rsp_tag, occupancy
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues one per cycle to a combinational ALU and returns tagged results.
// Optional result self-check enabled by defining ALU_CMD_SEQ_CHECK_EN.
module alu_cmd_sequencer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_cmd_sequencer_if.master  bus
`ifdef ALU_CMD_SEQ_CHECK_EN
  ,
  output logic                 chk_mismatch,
  output logic [15:0]          chk_err_count
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

  state_t           state_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q;
  logic [2:0]       rsp_opcode_q;
  logic [TAG_W-1:0] rsp_tag_q;

  logic [2:0]       fifo_op_q  [DEPTH];
  logic [WIDTH-1:0] fifo_a_q   [DEPTH];
  logic [WIDTH-1:0] fifo_b_q   [DEPTH];
  logic [TAG_W-1:0] fifo_tag_q [DEPTH];

  logic full, empty, push, issue;

  assign full  = (occ_q == OCC_W'(DEPTH));
  assign empty = (occ_q == '0);
  assign push  = bus.cmd_valid && !full;
  // A response slot is free when empty or being drained this same cycle.
  assign issue = !empty && (!rsp_valid_q || bus.rsp_ready);

  always_comb begin
    occ_d = occ_q;
    case ({push, issue})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    if (issue)
      rsp_valid_d = 1'b1;
    else if (rsp_valid_q && bus.rsp_ready)
      rsp_valid_d = 1'b0;
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_opcode_q <= '0;
      rsp_tag_q    <= '0;
    end else begin
      occ_q       <= occ_d;
      rsp_valid_q <= rsp_valid_d;
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (issue) begin
        rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
        rsp_result_q <= bus.alu_result;
        rsp_opcode_q <= fifo_op_q[rd_ptr_q];
        rsp_tag_q    <= fifo_tag_q[rd_ptr_q];
      end
      case (state_q)
        IDLE:    if (push) state_q <= RUN;
        RUN: begin
          if (rsp_valid_q && !bus.rsp_ready)
            state_q <= STALL;
          else if (occ_d == '0 && !rsp_valid_d && !push)
            state_q <= IDLE;
        end
        STALL:   if (bus.rsp_ready) state_q <= RUN;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Command storage carries no reset; occupancy alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_op_q[wr_ptr_q]  <= bus.cmd_opcode;
      fifo_a_q[wr_ptr_q]   <= bus.cmd_a;
      fifo_b_q[wr_ptr_q]   <= bus.cmd_b;
      fifo_tag_q[wr_ptr_q] <= bus.cmd_tag;
    end
  end

  assign bus.cmd_ready  = !full;
  assign bus.alu_issue  = issue;
  assign bus.alu_a      = issue ? fifo_a_q[rd_ptr_q]  : '0;
  assign bus.alu_b      = issue ? fifo_b_q[rd_ptr_q]  : '0;
  assign bus.alu_opcode = issue ? fifo_op_q[rd_ptr_q] : 3'b000;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_opcode = rsp_opcode_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.occupancy  = occ_q;

`ifdef ALU_CMD_SEQ_CHECK_EN
  function automatic logic [WIDTH-1:0] alu_model(input logic [2:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return {{(WIDTH-1){1'b0}}, (a > b)};
      3'b011:  return {{(WIDTH-1){1'b0}}, (a < b)};
      default: return '0;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        chk_mismatch_q;
  logic [15:0] chk_err_count_q;
  logic        chk_err;

  assign chk_err = issue &&
                   (bus.alu_result != alu_model(bus.alu_opcode, bus.alu_a, bus.alu_b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_mismatch_q  <= 1'b0;
      chk_err_count_q <= '0;
    end else if (chk_err) begin
      chk_mismatch_q  <= 1'b1;
      chk_err_count_q <= sat_inc(chk_err_count_q);
    end
  end

  assign chk_mismatch  = chk_mismatch_q;
  assign chk_err_count = chk_err_count_q;
`endif
endmodule
